// File: rtl/echo_pkg.sv
// Shared types and constants for the echo_delay audio block: FSM states, sample limits and
// active-low 7-segment glyphs.
package echo_pkg;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam logic [9:0]  MID    = 10'd512;

    localparam logic signed [10:0] SMAX = 11'sd511;
    localparam logic signed [10:0] SMIN = -11'sd512;

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StRead,
        StCalc,
        StWrite
    } state_e;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic signed [10:0] sat11(input logic signed [11:0] s);
        if (s > 12'sd511) begin
            return SMAX;
        end else if (s < -12'sd512) begin
            return SMIN;
        end
        return s[10:0];
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low 7-segment decoder.
module hex_to_7seg
    import echo_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_LUT[nibble_i];
    end

endmodule

// File: rtl/echo_delay.sv
// Variable-delay feedback echo: y = sat(x + y[n-D]/2), stored in an inferred delay RAM and
// sent to the DAC offset-binary; delay select shown in hex on four digits.
module echo_delay #(
    parameter int unsigned ADDR_W = echo_pkg::ADDR_W,
    parameter logic [9:0]  MID    = echo_pkg::MID
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic [9:0] data_in,
    input  logic       data_valid,
    input  logic [9:0] sw,
    output logic [9:0] data_out,
    output logic       ready,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3
);
    import echo_pkg::*;

    localparam int unsigned Depth = 2 ** ADDR_W;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  dly_q, dly_d;
    logic               byp_q, byp_d;
    logic signed [10:0] x_q, x_d;
    logic signed [10:0] y_q, y_d;
    logic [9:0]         data_out_q, data_out_d;
    logic [9:0]         sw_q;

    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_we;
    logic signed [10:0] ram_wdata;
    logic signed [10:0] ram_rdata;
    logic signed [10:0] fb;
    logic signed [11:0] sum;
    logic [15:0]        disp;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
            wr_ptr_q   <= '0;
            dly_q      <= '0;
            byp_q      <= 1'b1;
            x_q        <= '0;
            y_q        <= '0;
            data_out_q <= MID;
            sw_q       <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wr_ptr_q   <= wr_ptr_d;
            dly_q      <= dly_d;
            byp_q      <= byp_d;
            x_q        <= x_d;
            y_q        <= y_d;
            data_out_q <= data_out_d;
            sw_q       <= sw;
        end
    end

    assign fb  = ram_rdata >>> 1;
    assign sum = {x_q[10], x_q} + {fb[10], fb};

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wr_ptr_d   = wr_ptr_q;
        dly_d      = dly_q;
        byp_d      = byp_q;
        x_d        = x_q;
        y_d        = y_q;
        data_out_d = data_out_q;
        ram_we     = 1'b0;
        ram_addr   = wr_ptr_q - dly_q;
        ram_wdata  = y_q;

        unique case (state_q)
            StClear: begin
                ram_we     = 1'b1;
                ram_addr   = clr_addr_q;
                ram_wdata  = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                if (&clr_addr_q) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (data_valid) begin
                    x_d     = {1'b0, data_in} - {1'b0, MID};
                    dly_d   = ADDR_W'({sw, 3'b000});
                    byp_d   = (sw == '0);
                    state_d = StRead;
                end
            end
            StRead: begin
                state_d = StCalc;
            end
            StCalc: begin
                y_d     = byp_q ? x_q : sat11(sum);
                state_d = StWrite;
            end
            StWrite: begin
                ram_we     = 1'b1;
                ram_addr   = wr_ptr_q;
                data_out_d = y_q[9:0] + MID;
                wr_ptr_d   = wr_ptr_q + 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    // Single-port delay line, no reset so it maps onto block RAM.
    logic [10:0] mem [Depth];

    always_ff @(posedge sysclk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    assign data_out = data_out_q;
    assign ready    = (state_q == StIdle);
    assign disp     = {3'b000, sw_q, 3'b000};

    hex_to_7seg u_hex0 (.nibble_i(disp[3:0]),   .seg_o(hex0));
    hex_to_7seg u_hex1 (.nibble_i(disp[7:4]),   .seg_o(hex1));
    hex_to_7seg u_hex2 (.nibble_i(disp[11:8]),  .seg_o(hex2));
    hex_to_7seg u_hex3 (.nibble_i(disp[15:12]), .seg_o(hex3));

endmodule

// File: tb/tb_echo_delay.sv
// Directed bench for echo_delay with a reference model feeding an expected-output queue.
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            failures++; \
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); \
        end \
    end

module tb_echo_delay;
    import echo_pkg::DEPTH;

    logic       sysclk;
    logic       rst;
    logic [9:0] data_in;
    logic       data_valid;
    logic [9:0] sw;
    logic [9:0] data_out;
    logic       ready;
    logic [6:0] hex0, hex1, hex2, hex3;

    int checks;
    int failures;
    int exp_q[$];
    int mem_m[DEPTH];
    int ptr_m;

    echo_delay dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .data_in   (data_in),
        .data_valid(data_valid),
        .sw        (sw),
        .data_out  (data_out),
        .ready     (ready),
        .hex0      (hex0),
        .hex1      (hex1),
        .hex2      (hex2),
        .hex3      (hex3)
    );

    initial sysclk = 1'b0;
    always #10 sysclk = ~sysclk;

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            8:  return 7'b0000000;
            15: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic model(input int din, input int swv, output int dout);
        int x, r, y;
        x = din - 512;
        if (swv == 0) begin
            y = x;
        end else begin
            r = mem_m[(ptr_m - swv * 8) & (DEPTH - 1)];
            y = x + (r >>> 1);
            if (y > 511) y = 511;
            if (y < -512) y = -512;
        end
        mem_m[ptr_m] = y;
        ptr_m = (ptr_m + 1) % DEPTH;
        dout = y + 512;
    endtask

    task automatic send(input int din, input int swv, input string tag);
        int e;
        @(negedge sysclk);
        sw         = 10'(swv);
        data_in    = 10'(din);
        data_valid = 1'b1;
        model(din, swv, e);
        exp_q.push_back(e);
        @(negedge sysclk);
        data_valid = 1'b0;
        `CHK("busy_ready", ready, 1'b0);
        repeat (2) @(negedge sysclk);
        `CHK("busy_ready_late", ready, 1'b0);
        @(negedge sysclk);
        e = exp_q.pop_front();
        `CHK(tag, data_out, 10'(e));
        `CHK("idle_ready", ready, 1'b1);
    endtask

    task automatic reset_and_clear();
        int cnt;
        bit done;
        rst        = 1'b1;
        data_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
        ptr_m = 0;
        exp_q.delete();
        repeat (3) @(negedge sysclk);
        checks++;
        if (data_out !== 10'd512 || ready !== 1'b0) begin
            failures++;
            $error("FAIL rst_state: data_out %0d ready %0b", data_out, ready);
        end
        rst  = 1'b0;
        cnt  = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge sysclk);
            cnt++;
            data_valid = 1'b0;
            if (ready || cnt > 9000) begin
                done = 1'b1;
            end else begin
                data_valid = (cnt % 100 == 0);
                `CHK("clear_dout", data_out, 10'd512);
            end
        end
        data_valid = 1'b0;
        checks++;
        if (cnt > 9000) begin
            failures++;
            $error("FAIL clear_timeout: ready never rose within %0d cycles", cnt);
        end
        `CHK("clear_cycles", cnt, 8192);
    endtask

    initial begin
        int e;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        data_in    = '0;
        data_valid = 1'b0;
        sw         = '0;
        #1;
        `CHK("por_dout", data_out, 10'd512);
        `CHK("por_ready", ready, 1'b0);
        `CHK("por_hex0", hex0, seg_of(0));
        `CHK("por_hex3", hex3, seg_of(0));

        reset_and_clear();

        // Impulse with D=8: echoes 767, 639, 575 at n=8,16,24.
        for (int n = 0; n < 30; n++) begin
            send((n == 0) ? 1023 : 512, 1, "impulse");
        end
        for (int n = 0; n < 12; n++) send(1023, 1, "sat_high");
        for (int n = 0; n < 12; n++) send(0, 1, "sat_low");

        send(700, 0, "bypass_700");
        send(300, 0, "bypass_300");
        send(512, 0, "bypass_512");

        @(negedge sysclk);
        sw = 10'h3FF;
        #1;
        `CHK("hex_latency", hex0, seg_of(0));
        @(negedge sysclk);
        `CHK("hex3_3ff", hex3, seg_of(1));
        `CHK("hex2_3ff", hex2, seg_of(15));
        `CHK("hex1_3ff", hex1, seg_of(15));
        `CHK("hex0_3ff", hex0, seg_of(8));
        sw = 10'h001;
        @(negedge sysclk);
        `CHK("hex3_001", hex3, seg_of(0));
        `CHK("hex2_001", hex2, seg_of(0));
        `CHK("hex1_001", hex1, seg_of(0));
        `CHK("hex0_001", hex0, seg_of(8));

        // Cross the write-pointer wrap with periodic impulses.
        for (int n = 0; n < 8200; n++) begin
            send((n % 50 == 0) ? 1023 : 512, 1, "wrap");
        end

        // Abort a transaction while it sits in CALC.
        @(negedge sysclk);
        sw         = 10'd1;
        data_in    = 10'd900;
        data_valid = 1'b1;
        model(900, 1, e);
        @(negedge sysclk);
        data_valid = 1'b0;
        @(negedge sysclk);
        #2;
        rst = 1'b1;
        #1;
        `CHK("abort_dout", data_out, 10'd512);
        `CHK("abort_ready", ready, 1'b0);
        reset_and_clear();
        for (int n = 0; n < 20; n++) send(512, 1, "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
